modcounter_param: RTL and testbench
===================================

# modcounter_param

Parametrised modulo-N up/down counter: the general-purpose successor to the fixed 4-bit loadable mod counter. It adds configurable width and modulus, count enable, direction control, wrap or saturate mode, range-checked parallel load, and a terminal-count output for cascading stages. It is used as a timebase, divider and sequence index wherever a bounded counter is needed.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `MOD`, default 10: modulus; the count range is 0..MOD-1. Legal range is 2 <= MOD <= 2^WIDTH.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `en`  in  1  count enable.
- `up_dn`  in  1  direction: 1 counts up, 0 counts down.
- `sat`  in  1  mode: 0 wraps at the range ends, 1 saturates (holds) at the range ends.
- `lde`  in  1  parallel load enable.
- `ld`  in  WIDTH  parallel load value.
- `Q`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal count, combinational; used as `en` of the next cascaded stage.
- `wrap`  out  1  registered single-cycle pulse marking a wrap event.
- `ld_err`  out  1  registered single-cycle pulse marking an out-of-range load.

## Operation
- Per-edge priority: reset, then load (`lde`), then count (`en`). Load takes effect regardless of `en`.
- **Load, `ld` < MOD:** Q <= ld.
- **Load, `ld` >= MOD:** Q <= MOD-1 and `ld_err` = 1 for the next cycle.
- **Count up (`en`=1, `up_dn`=1):**
  - If Q < MOD-1: Q <= Q+1.
  - If Q = MOD-1 and `sat`=0: Q <= 0 and `wrap` pulses.
  - If Q = MOD-1 and `sat`=1: Q holds; no `wrap`.
- **Count down (`en`=1, `up_dn`=0):**
  - If Q > 0: Q <= Q-1.
  - If Q = 0 and `sat`=0: Q <= MOD-1 and `wrap` pulses.
  - If Q = 0 and `sat`=1: Q holds.
- **Idle (`en`=0, `lde`=0):** Q holds.
- **`tc`** = `en` & ((`up_dn` & Q==MOD-1) | (!`up_dn` & Q==0)).
  - `tc` is independent of `sat`.
  - `tc` is low while `lde`=1.
- **Arithmetic:** Q never leaves 0..MOD-1. When MOD = 2^WIDTH, natural overflow gives the same result as explicit wrap. All compares are WIDTH bits wide.
- **Direction or mode change:** takes effect on the same edge; there is no hidden state.

## Timing
- Reset values: Q=0, `wrap`=0, `ld_err`=0 (and `wrap_cnt`=0 when configured).
- Reset assertion clears all outputs immediately, with no clock required. Deassertion is synchronised externally.
- Load latency is 1 cycle: Q shows `ld` after the edge that samples `lde`=1.
- Count latency is 1 cycle per enabled edge.
- `wrap` and `ld_err` are high for exactly the one cycle after the event edge. They do not stretch, even when wraps occur back to back.
- `tc` follows its inputs combinationally in the same cycle. Cascaded stages step on the same edge on which the lower stage wraps.
- Reset mid-count aborts the count. The first enabled edge after release counts from 0.
- `lde` and `en` high together: the load wins and no count happens that cycle.

## Configuration
- Macro: `MODCNT_WRAPCNT_EN`.
- **Defined:** adds the output `wrap_cnt` (out, 8 bits).
  - Increments on every wrap event.
  - Saturates at 255.
  - Clears on reset and on any load.
- **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=4, MOD=10.

- **Reset:** `rst`=0 mid-count at Q=6, asynchronously between edges -> Q=0, `wrap`=0, `ld_err`=0 immediately. After release with `en`=1, `up_dn`=1: Q = 1, 2, 3.
- **Up wrap:** load 8, then `en`=1, `up_dn`=1, `sat`=0 -> Q = 8, 9, 0, 1. `tc`=1 while Q=9. `wrap`=1 the cycle Q=0 is shown. `wrap_cnt`=1 if configured.
- **Down saturate:** load 1, then `up_dn`=0, `sat`=1 -> Q = 1, 0, 0, 0. `tc`=1 at Q=0. `wrap` stays 0.
- **Out-of-range load:** `lde`=1 with `ld`=12 -> Q=9 and a 1-cycle `ld_err`. A following `ld`=3 -> Q=3 and `ld_err`=0.
- **Load vs count:** `lde`=1, `ld`=5, `en`=1 at Q=2 -> Q=5 (not 3). `tc`=0 during the load cycle.
- **Cascade:** two instances, the upper stage's `en` driven by the lower stage's `tc`, counting up for 25 edges from 0 -> lower Q=5, upper Q=2. The upper stage steps on exactly the edges where the lower stage goes 9->0.

Source files
------------

// File: rtl/modcounter_param.sv
// ============================================================================
//  Module   : modcounter_param
//  Purpose  : Parametrised modulo-MOD up/down counter with wrap/saturate mode,
//             range-checked load and terminal count for cascading.
//             Optional wrap event counter enabled by macro MODCNT_WRAPCNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module modcounter_param #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             lde,
  input  logic [WIDTH-1:0] ld,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap,
  output logic             ld_err
`ifdef MODCNT_WRAPCNT_EN
  ,
  output logic [7:0]       wrap_cnt
`endif
);

  // Top of range held at WIDTH bits so MOD == 2^WIDTH needs no extra bit.
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             err_next;

  assign at_max  = (Q == MAX);
  assign at_zero = (Q == '0);
  assign tc      = en & ~lde & ((up_dn & at_max) | (~up_dn & at_zero));

  always_comb begin
    q_next    = Q;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (lde) begin
      if (ld > MAX) begin
        q_next   = MAX;
        err_next = 1'b1;
      end else begin
        q_next   = ld;
      end
    end else if (en) begin
      if (up_dn) begin
        if (!at_max) begin
          q_next = Q + ONE;
        end else if (!sat) begin
          q_next    = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          q_next = Q - ONE;
        end else if (!sat) begin
          q_next    = MAX;
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Q      <= '0;
      wrap   <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      Q      <= q_next;
      wrap   <= wrap_next;
      ld_err <= err_next;
    end
  end

`ifdef MODCNT_WRAPCNT_EN
  // Any load restarts the wrap tally; it sticks at 255 rather than rolling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_cnt <= 8'd0;
    end else if (lde) begin
      wrap_cnt <= 8'd0;
    end else if (wrap_next && (wrap_cnt != 8'hFF)) begin
      wrap_cnt <= wrap_cnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_modcounter_param.sv
// ============================================================================
//  Module   : tb_modcounter_param
//  Purpose  : Self-checking bench for modcounter_param (WIDTH=4, MOD=10).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_modcounter_param;
  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk;
  logic             rst;
  logic             en, up_dn, sat, lde;
  logic [WIDTH-1:0] ld;
  logic [WIDTH-1:0] q;
  logic             tc, wrap, ld_err;
  logic             c_en;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             lo_tc, hi_tc, lo_wrap, hi_wrap, lo_err, hi_err;
`ifdef MODCNT_WRAPCNT_EN
  logic [7:0]       wrap_cnt, lo_wc, hi_wc;
`endif

  int checks   = 0;
  int failures = 0;

  modcounter_param #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .lde(lde), .ld(ld),
    .Q(q), .tc(tc), .wrap(wrap), .ld_err(ld_err)
`ifdef MODCNT_WRAPCNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  modcounter_param #(.WIDTH(WIDTH), .MOD(MOD)) lo (
    .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .sat(1'b0), .lde(1'b0), .ld(4'd0),
    .Q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .ld_err(lo_err)
`ifdef MODCNT_WRAPCNT_EN
    , .wrap_cnt(lo_wc)
`endif
  );

  modcounter_param #(.WIDTH(WIDTH), .MOD(MOD)) hi (
    .clk(clk), .rst(rst), .en(lo_tc), .up_dn(1'b1), .sat(1'b0), .lde(1'b0), .ld(4'd0),
    .Q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .ld_err(hi_err)
`ifdef MODCNT_WRAPCNT_EN
    , .wrap_cnt(hi_wc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Reference model: counter state as plain integers, rules applied with modular arithmetic.
  int m_q, m_wrap, m_err, m_wc;

  function automatic int model_tc(input int cq, input bit e, input bit u, input bit l);
    if (l || !e) return 0;
    return (u ? (cq == MOD - 1) : (cq == 0)) ? 1 : 0;
  endfunction

  task automatic model_step(input bit l, input int lv, input bit e, input bit u, input bit s);
    int nxt;
    m_wrap = 0;
    m_err  = 0;
    if (l) begin
      if (lv < MOD) m_q = lv;
      else begin m_q = MOD - 1; m_err = 1; end
      m_wc = 0;
    end else if (e) begin
      nxt = u ? m_q + 1 : m_q - 1;
      if (nxt >= 0 && nxt < MOD) m_q = nxt;
      else if (!s) begin
        m_q    = (nxt + MOD) % MOD;
        m_wrap = 1;
        if (m_wc < 255) m_wc++;
      end
    end
  endtask

  typedef struct {
    logic       lde;
    logic [3:0] ld;
    logic       en, up_dn, sat;
    logic       exp_tc;
    logic [3:0] exp_q;
    logic       exp_wrap, exp_err;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mkv(input logic l, input logic [3:0] lv, input logic e,
                               input logic u, input logic s, input logic t,
                               input logic [3:0] eq, input logic w, input logic er);
    vec_t v;
    v.lde = l; v.ld = lv; v.en = e; v.up_dn = u; v.sat = s;
    v.exp_tc = t; v.exp_q = eq; v.exp_wrap = w; v.exp_err = er;
    return v;
  endfunction

  initial begin
    //                l  ld  en up sat tc  q  wrap err
    vecs[0]  = mkv(1, 8,  0, 1, 0,  0, 8, 0, 0);
    vecs[1]  = mkv(0, 0,  1, 1, 0,  0, 9, 0, 0);
    vecs[2]  = mkv(0, 0,  1, 1, 0,  1, 0, 1, 0);
    vecs[3]  = mkv(0, 0,  1, 1, 0,  0, 1, 0, 0);
    vecs[4]  = mkv(1, 1,  0, 0, 1,  0, 1, 0, 0);
    vecs[5]  = mkv(0, 0,  1, 0, 1,  0, 0, 0, 0);
    vecs[6]  = mkv(0, 0,  1, 0, 1,  1, 0, 0, 0);
    vecs[7]  = mkv(0, 0,  1, 0, 1,  1, 0, 0, 0);
    vecs[8]  = mkv(0, 0,  1, 0, 0,  1, 9, 1, 0);
    vecs[9]  = mkv(0, 0,  1, 1, 0,  1, 0, 1, 0);
    vecs[10] = mkv(0, 0,  1, 0, 0,  1, 9, 1, 0);
    vecs[11] = mkv(0, 0,  0, 1, 0,  0, 9, 0, 0);
    vecs[12] = mkv(0, 0,  1, 1, 1,  1, 9, 0, 0);
    vecs[13] = mkv(1, 12, 0, 1, 0,  0, 9, 0, 1);
    vecs[14] = mkv(1, 3,  0, 1, 0,  0, 3, 0, 0);
    vecs[15] = mkv(1, 15, 0, 1, 0,  0, 9, 0, 1);
    vecs[16] = mkv(0, 0,  0, 1, 0,  0, 9, 0, 0);
    vecs[17] = mkv(1, 2,  0, 1, 0,  0, 2, 0, 0);
    vecs[18] = mkv(1, 5,  1, 1, 0,  0, 5, 0, 0);
    vecs[19] = mkv(1, 9,  0, 1, 0,  0, 9, 0, 0);
    vecs[20] = mkv(1, 4,  1, 1, 0,  0, 4, 0, 0);
    vecs[21] = mkv(1, 9,  0, 1, 0,  0, 9, 0, 0);
    vecs[22] = mkv(0, 0,  0, 1, 0,  0, 9, 0, 0);

    rst = 1'b0; en = 1'b0; up_dn = 1'b1; sat = 1'b0; lde = 1'b0; ld = '0; c_en = 1'b0;

    // Reset state, then count to 6 and drop reset between edges.
    edge_sample();
    edge_sample();
    check("reset_q", q, 0);
    check("reset_wrap", wrap, 0);
    check("reset_ld_err", ld_err, 0);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    repeat (6) edge_sample();
    check("pre_reset_q", q, 6);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_q", q, 0);
    check("async_reset_wrap", wrap, 0);
    check("async_reset_ld_err", ld_err, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      edge_sample();
      check("post_reset_count", q, k);
    end

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      lde = vecs[i].lde; ld = vecs[i].ld; en = vecs[i].en;
      up_dn = vecs[i].up_dn; sat = vecs[i].sat;
      #1;
      check($sformatf("vec%0d_tc", i), tc, vecs[i].exp_tc);
      edge_sample();
      check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d_wrap", i), wrap, vecs[i].exp_wrap);
      check($sformatf("vec%0d_ld_err", i), ld_err, vecs[i].exp_err);
`ifdef MODCNT_WRAPCNT_EN
      if (i == 2) check("vec2_wrap_cnt", wrap_cnt, 1);
`endif
    end

    // Randomised run against the reference model, starting from the table's end state.
    m_q = 9; m_wrap = 0; m_err = 0; m_wc = 0;
    for (int i = 0; i < 400; i++) begin
      lde   = ($urandom_range(0, 7) == 0);
      ld    = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 3) != 0);
      up_dn = 1'($urandom);
      sat   = ($urandom_range(0, 3) == 0);
      #1;
      check("rand_tc", tc, model_tc(m_q, en, up_dn, lde));
      model_step(lde, int'(ld), en, up_dn, sat);
      edge_sample();
      check("rand_q", q, m_q);
      check("rand_wrap", wrap, m_wrap);
      check("rand_ld_err", ld_err, m_err);
`ifdef MODCNT_WRAPCNT_EN
      check("rand_wrap_cnt", wrap_cnt, m_wc);
`endif
    end

    // Cascade: two stages from 0, lower stage tc enabling the upper stage.
    lde = 1'b0; en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("cascade_reset_lo", lo_q, 0);
    @(negedge clk);
    rst  = 1'b1;
    c_en = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      edge_sample();
      check("cascade_lo", lo_q, k % MOD);
      check("cascade_hi", hi_q, (k / MOD) % MOD);
    end
    c_en = 1'b0;
    check("cascade_final_lo", lo_q, 5);
    check("cascade_final_hi", hi_q, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
